// File: rtl/esm_hazard_sequencer_pkg.sv
// Shared definitions for the ESM hazard sequencer: opcodes, bubble encoding,
// sequencer states, scoreboard entry layout and operand-usage decode helpers.
package esm_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // FIFO payload: {instr[31:0], ALUSrc, RegWrite}
  localparam int FIFO_W = 34;

  typedef enum logic [1:0] {IDLE, ISSUE, STALL} esm_state_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op, input logic alusrc);
    return !alusrc || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/esm_hazard_sequencer_if.sv
// Instruction-in / issue-out bundle between the instruction source and the
// ESM hazard sequencer.
interface esm_hazard_sequencer_if;
  logic [31:0] Instr_in;
  logic        ALUSrc;
  logic        RegWrite;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Instr_out;
  logic        out_valid;
  logic        out_bubble;

  modport master (
    output Instr_in, ALUSrc, RegWrite, in_valid,
    input  in_ready, Instr_out, out_valid, out_bubble
  );

  modport slave (
    input  Instr_in, ALUSrc, RegWrite, in_valid,
    output in_ready, Instr_out, out_valid, out_bubble
  );
endinterface

// File: rtl/esm_instr_fifo.sv
// Synchronous FIFO for instruction + sideband words; an occupancy counter
// separates full from empty so the pointers can wrap freely.
module esm_instr_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; stale entries are never read past the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/esm_hazard_sequencer.sv
// Buffered RV32 issue stage that inserts NOP bubbles on RAW hazards against the
// last HAZARD_DEPTH issued slots; ESM_FORWARDING_EN restricts stalls to load-use.
module esm_hazard_sequencer #(
  parameter int HAZARD_DEPTH = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input logic                  clk,
  input logic                  rst,
  esm_hazard_sequencer_if.slave bus
);
  import esm_pkg::*;

  logic [FIFO_W-1:0] head;
  logic              fifo_full, fifo_empty;
  logic [31:0]       head_instr;
  logic              head_alusrc, head_regwrite;
  logic [6:0]        opcode;
  logic [4:0]        rd, rs1, rs2;
  logic              use_rs1, use_rs2, hazard, issue;

  esm_state_t  state_q, state_d;
  logic [31:0] instr_out_q, instr_out_d;
  sb_entry_t   sb_q [HAZARD_DEPTH];
  sb_entry_t   sb_d [HAZARD_DEPTH];

  esm_instr_fifo #(
    .W     (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (issue),
    .wdata ({bus.Instr_in, bus.ALUSrc, bus.RegWrite}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_instr, head_alusrc, head_regwrite} = head;
  assign opcode  = head_instr[6:0];
  assign rd      = head_instr[11:7];
  assign rs1     = head_instr[19:15];
  assign rs2     = head_instr[24:20];
  assign use_rs1 = uses_rs1(opcode);
  assign use_rs2 = uses_rs2(opcode, head_alusrc);

  // The head's own rd is never compared, so self-dependence cannot stall.
  always_comb begin
    hazard = 1'b0;
`ifdef ESM_FORWARDING_EN
    if (sb_q[0].v && sb_q[0].is_load &&
        ((use_rs1 && (rs1 != 5'd0) && (rs1 == sb_q[0].rd)) ||
         (use_rs2 && (rs2 != 5'd0) && (rs2 == sb_q[0].rd))))
      hazard = 1'b1;
`else
    for (int i = 0; i < HAZARD_DEPTH; i++) begin
      if (sb_q[i].v &&
          ((use_rs1 && (rs1 != 5'd0) && (rs1 == sb_q[i].rd)) ||
           (use_rs2 && (rs2 != 5'd0) && (rs2 == sb_q[i].rd))))
        hazard = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d     = IDLE;
    instr_out_d = NOP_INSTR;
    if (!fifo_empty) begin
      if (hazard) begin
        state_d = STALL;
      end else begin
        state_d     = ISSUE;
        instr_out_d = head_instr;
      end
    end
  end

  assign issue = (state_d == ISSUE);

  // Scoreboard shifts every cycle; bubbles and idle slots enter as invalid.
  always_comb begin
    sb_d[0] = '0;
    if (issue) begin
      sb_d[0].v       = head_regwrite && (rd != 5'd0);
      sb_d[0].rd      = rd;
      sb_d[0].is_load = (opcode == OP_LOAD);
    end
    for (int i = 1; i < HAZARD_DEPTH; i++) sb_d[i] = sb_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      instr_out_q <= NOP_INSTR;
      for (int i = 0; i < HAZARD_DEPTH; i++) sb_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      instr_out_q <= instr_out_d;
      for (int i = 0; i < HAZARD_DEPTH; i++) sb_q[i] <= sb_d[i];
    end
  end

  assign bus.in_ready   = !fifo_full;
  assign bus.Instr_out  = instr_out_q;
  assign bus.out_valid  = (state_q != IDLE);
  assign bus.out_bubble = (state_q == STALL);

endmodule

// File: doc/esm_hazard_sequencer.md
# esm_hazard_sequencer

Parametrised instruction-stream sequencer that sits between the instruction source and the ESM execution path. Buffers incoming 32-bit RV32 instructions with their `ALUSrc`/`RegWrite` sidebands in a small FIFO. Tracks the destinations of the last `HAZARD_DEPTH` issued slots in a scoreboard and inserts NOP bubbles (`0x00000013`) whenever the head instruction reads a register still in flight. It is the successor of the fixed single-path ESM front end: configurable hazard window, configurable buffering, valid/ready input and optional load-use forwarding mode.

## Interface
- `HAZARD_DEPTH`, default 2: number of issued slots a producer blocks consumers for (1..4).
- `FIFO_DEPTH`, default 4: input buffer entries, power of two, at least 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `Instr_in` input 32: incoming instruction.
- `ALUSrc` input 1: sideband; 1 means the operand-2 field is an immediate.
- `RegWrite` input 1: sideband; 1 means the instruction writes `rd`.
- `in_valid` input 1: `Instr_in`/`ALUSrc`/`RegWrite` are valid this cycle.
- `in_ready` output 1: block can accept this cycle.
- `Instr_out` output 32: issued instruction or bubble, registered.
- `out_valid` output 1: `Instr_out` is a real slot, either an instruction or a bubble.
- `out_bubble` output 1: `Instr_out` is an inserted NOP.

## Operation
- **Accept:** on a rising edge with `in_valid && in_ready`, push {Instr_in, ALUSrc, RegWrite} into the FIFO.
- **in_ready:** `in_ready = !full`. A simultaneous pop does not free space in the same cycle.
- **Decode of the FIFO head:**
  - opcode = [6:0], rd = [11:7], rs1 = [19:15], rs2 = [24:20].
  - rs1 is used unless opcode ∈ {0110111, 0010111, 1101111}.
  - rs2 is used iff `ALUSrc==0` or opcode == 0100011 (store).
  - A load is opcode 0000011.
- **Scoreboard:** shift register of `HAZARD_DEPTH` entries {v, rd, is_load}; entry 0 is the most recent.
  - Shifts every cycle the block is out of reset.
  - An issued instruction shifts in {RegWrite && rd!=0, rd, is_load}.
  - A bubble or idle cycle shifts in v=0.
- **Hazard:** a used source is nonzero and equals rd of any valid entry.
  - Register x0 never creates a hazard.
  - Self-dependence, e.g. rd==rs1 in the same instruction, is not a hazard.
- **State machine:**
  - IDLE: FIFO empty. Next edge: `out_valid=0`, `out_bubble=0`, `Instr_out=0x00000013`.
  - ISSUE: head present, no hazard. Next edge: pop the head, `Instr_out`=head, `out_valid=1`, `out_bubble=0`.
  - STALL: head present, hazard. Next edge: no pop, `Instr_out=0x00000013`, `out_valid=1`, `out_bubble=1`.
  - The state is re-evaluated every cycle from FIFO occupancy and the hazard check. No extra latency between states.
- **Reset:** `rst` asserted at any time, including mid-stall, immediately clears:
  - FIFO pointers and count to 0 and all scoreboard valids to 0.
  - `Instr_out` to 0x00000013, `out_valid` to 0, `out_bubble` to 0.
  - `in_ready` goes to 1 combinationally from the empty FIFO.
  - Instructions buffered at reset are dropped.

## Timing
- Latency: an instruction accepted at edge k into an empty FIFO with no hazard appears on `Instr_out` after edge k+1.
- Throughput: one issue per cycle when free of hazards.
- Producer issued at edge j: a dependent consumer issues no earlier than edge j+HAZARD_DEPTH+1. With the default depth this gives exactly 2 bubbles when back-to-back.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. Full and empty are distinguished by a count register.

## Configuration
- `ESM_FORWARDING_EN` defined:
  - Only load-use is a hazard: the head's source matches entry 0 and entry 0 has is_load=1.
  - Load-use costs exactly 1 bubble.
  - Scoreboard entries 1..HAZARD_DEPTH-1 are ignored.
- `ESM_FORWARDING_EN` undefined: full-window rule as above.

## Structure
- Shared package `esm_pkg` holds:
  - opcode constants (OP_R 0110011, OP_IMM 0010011, OP_LOAD 0000011, OP_STORE 0100011, OP_LUI, OP_AUIPC, OP_JAL);
  - `NOP_INSTR = 32'h00000013`;
  - the state enum {IDLE, ISSUE, STALL};
  - the scoreboard-entry struct.
- One sub-module: `esm_instr_fifo`, a synchronous FIFO parametrised by width (34) and `FIFO_DEPTH`, with count, full and empty.

## Test plan
All scenarios use defaults, no macro, unless stated.
- **Back-to-back dependence:** 0x00100093 then 0xFFF08093, both RegWrite=1, ALUSrc=1. `Instr_out` sequence: 0x00100093, bubble, bubble, 0xFFF08093, with `out_bubble` = 0,1,1,0.
- **Dependence after independent instructions:** 0x00200393, 0x00500413, 0x008384B3 (ALUSrc=0). First two issue consecutively, then 2 bubbles, then 0x008384B3.
- **ALUSrc gating of rs2:** 0x00200393 then 0x00700513 (imm field aliases x7). With ALUSrc=1: no bubble. Repeated with ALUSrc=0: 2 bubbles.
- **FIFO full:** hold `in_valid=1` while stalled on a dependence chain. `in_ready` falls after 4 accepts and rises the cycle after the first pop.
- **Reset mid-stall:** pulse `rst` between clock edges while `out_bubble=1`. Outputs immediately read 0x00000013/0/0, `in_ready=1`, FIFO empty; the next instruction issues with no bubbles.
- **Forwarding:** with `ESM_FORWARDING_EN`, 0x0000A283 then 0x00528333 gives 1 bubble; 0x00100093 then 0xFFF08093 gives 0 bubbles. Without the macro both give 2 bubbles.
